// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP capture front end.
// Imported by the input stage and the capture top.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VSYNC,
    FRAME
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int DVP_H_ACTIVE = 640;
  localparam int DVP_V_ACTIVE = 480;

endpackage

// File: rtl/dvp_sync_in.sv
// DVP input register stage with href fall and vsync rise/fall pulses.
// Vsync is normalised so that 1 always means "in vertical sync".
module dvp_sync_in
  import dvp_pkg::*;
#(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pixel,
  input  logic       i_href,
  input  logic       i_vsync,
  output logic [7:0] o_byte,
  output logic       o_href,
  output logic       o_href_fall,
  output logic       o_vs_rise,
  output logic       o_vs_fall
);

  logic [7:0] r_byte;
  logic       r_href;
  logic       r_href_d;
  logic       r_vs;
  logic       r_vs_d;
  logic       w_vs_n;

  assign w_vs_n = (i_vsync == VSYNC_POL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte   <= '0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
    end else begin
      r_byte   <= i_pixel;
      r_href   <= i_href;
      r_href_d <= r_href;
      r_vs     <= w_vs_n;
      r_vs_d   <= r_vs;
    end
  end

  assign o_byte      = r_byte;
  assign o_href      = r_href;
  assign o_href_fall = r_href_d & ~r_href;
  assign o_vs_rise   = r_vs & ~r_vs_d;
  assign o_vs_fall   = r_vs_d & ~r_vs;

endmodule

// File: rtl/dvp_capture.sv
// DVP byte stream to framed RGB565 pixels with SOF/EOL markers,
// frame counting and sticky line/frame length error flags.
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 12
) (
  input  logic        dvp_clk,
  input  logic        rst,
  input  logic [7:0]  dvp_pixel,
  input  logic        dvp_href,
  input  logic        dvp_vsync,
  input  logic        err_clr,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_line_len,
  output logic        err_frame_len
);

  localparam logic [CNT_W-1:0] LP_H   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_HM1 = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LP_V   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_MAX = '1;
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic [7:0]       w_byte;
  logic             w_href;
  logic             w_href_fall;
  logic             w_vs_rise;
  logic             w_vs_fall;

  cap_state_t       r_state;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_phase;
  logic [7:0]       r_hi;
  rgb565_t          r_pix;
  logic             r_valid;
  logic             r_sof;
  logic             r_eol;
  logic             r_done;
  logic [15:0]      r_frames;
  logic             r_err_line;
  logic             r_err_frame;

  dvp_sync_in #(
    .VSYNC_POL (VSYNC_POL)
  ) u_sync (
    .i_clk       (dvp_clk),
    .i_rst       (rst),
    .i_pixel     (dvp_pixel),
    .i_href      (dvp_href),
    .i_vsync     (dvp_vsync),
    .o_byte      (w_byte),
    .o_href      (w_href),
    .o_href_fall (w_href_fall),
    .o_vs_rise   (w_vs_rise),
    .o_vs_fall   (w_vs_fall)
  );

  always_ff @(posedge dvp_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_pix       <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_done      <= 1'b0;
      r_frames    <= '0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_done  <= 1'b0;
      // Clear first so a same-cycle error set below takes priority
      if (err_clr) begin
        r_err_line  <= 1'b0;
        r_err_frame <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (w_vs_rise) r_state <= VSYNC;
        end
        VSYNC: begin
          if (w_vs_fall) begin
            r_state <= FRAME;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
          end
        end
        FRAME: begin
          if (w_vs_rise) begin
            r_state  <= VSYNC;
            r_done   <= 1'b1;
            r_frames <= r_frames + 16'd1;
            if (r_y != LP_V) r_err_frame <= 1'b1;
            // A line still in progress is cut and never counted
            if (w_href || r_phase || (r_x != '0)) r_err_line <= 1'b1;
          end else if (w_href_fall) begin
            if ((r_y < LP_V) && (r_phase || (r_x != LP_H)))
              r_err_line <= 1'b1;
            if (r_y != LP_MAX) r_y <= r_y + LP_ONE;
            r_x     <= '0;
            r_phase <= 1'b0;
          end else if (w_href) begin
            if (!r_phase) begin
              r_hi    <= w_byte;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_x != LP_MAX) r_x <= r_x + LP_ONE;
              if (r_y < LP_V) begin
                if (r_x < LP_H) begin
                  r_valid <= 1'b1;
                  r_pix   <= rgb565_t'({r_hi, w_byte});
                  r_sof   <= (r_x == '0) && (r_y == '0);
                  r_eol   <= (r_x == LP_HM1);
                end else begin
                  r_err_line <= 1'b1;
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix_data      = r_pix;
  assign pix_valid     = r_valid;
  assign pix_sof       = r_sof;
  assign pix_eol       = r_eol;
  assign frame_done    = r_done;
  assign frame_cnt     = r_frames;
  assign err_line_len  = r_err_line;
  assign err_frame_len = r_err_frame;

endmodule
